pixel_compose: RTL

Output stage directly downstream of the GPU sprite/layer selector. It takes the per-pixel `display_type` and `read_address` decision for the current beam position and issues reads to the sprite ROM bank and the background frame ROM. It then merges the returned colours with colour-key transparency and drives aligned RGB and sync to the VGA pins. All sync and enable signals are delayed to match memory latency, so every output pixel corresponds exactly to the input pixel it was computed from.

---
 rtl/pixel_compose_if.sv | 19 +
 rtl/pixel_compose.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pixel_compose_if.sv
// Memory-side bus between pixel_compose and the sprite ROM bank / background frame ROM.
// The compositor drives the read addresses, and the ROMs return data a fixed number of cycles later.
interface pixel_compose_if;
  logic [7:0]  spr_sel;
  logic [18:0] spr_addr;
  logic [23:0] spr_data;
  logic [18:0] bg_addr;
  logic [23:0] bg_data;

  modport master (
    output spr_sel, spr_addr, bg_addr,
    input  spr_data, bg_data
  );

  modport slave (
    input  spr_sel, spr_addr, bg_addr,
    output spr_data, bg_data
  );
endinterface

// File: rtl/pixel_compose.sv
// VGA output stage: issues sprite/background ROM reads for each beam pixel, then merges the returned colours
// with colour-key transparency. Syncs and enable are delayed so they stay aligned with the pixel colour.
module pixel_compose #(
  parameter int          MEM_LAT   = 2,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF,
  parameter logic [23:0] FILL_32   = 24'hE01010,
  parameter logic [23:0] FILL_34   = 24'h202020
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic                   hs_in,
  input  logic                   vs_in,
  input  logic                   de_in,
  input  logic [7:0]             display_type,
  input  logic [18:0]            read_address,
  pixel_compose_if.master        mem,
  output logic [7:0]             Red,
  output logic [7:0]             Green,
  output logic [7:0]             Blue,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic                   de_out
);

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] dtype;
  } tag_t;

  localparam tag_t TAG_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, dtype: 8'h00};

  logic        r_run;
  tag_t        r_tagA;
  tag_t        r_tagB [MEM_LAT];
  tag_t        w_tagC;
  logic [7:0]  r_sprSel;
  logic [18:0] r_sprAddr;
  logic [18:0] r_bgAddr;
  logic        w_inRange;
  logic [18:0] w_bgAddr;
  logic [23:0] w_rgb;
  logic [23:0] r_rgb;
  logic        r_hs;
  logic        r_vs;
  logic        r_de;

  // Release is taken one edge late, so stage A first captures on the second edge after Reset_n rises
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_run <= 1'b0;
    else          r_run <= 1'b1;
  end

  assign w_inRange = (DrawX < 10'd640) && (DrawY < 10'd480);
  assign w_bgAddr  = ({9'd0, DrawY} * 19'd640) + {9'd0, DrawX};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tagA    <= TAG_IDLE;
      r_sprSel  <= '0;
      r_sprAddr <= '0;
      r_bgAddr  <= '0;
    end else if (r_run) begin
      r_tagA    <= '{de: de_in && w_inRange, hs: hs_in, vs: vs_in, dtype: display_type};
      r_sprSel  <= display_type;
      r_sprAddr <= read_address;
      r_bgAddr  <= w_inRange ? w_bgAddr : '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < MEM_LAT; i++) r_tagB[i] <= TAG_IDLE;
    end else begin
      r_tagB[0] <= r_tagA;
      for (int i = 1; i < MEM_LAT; i++) r_tagB[i] <= r_tagB[i-1];
    end
  end

  assign w_tagC = r_tagB[MEM_LAT-1];

  // The tag leaving the last delay stage belongs to the same pixel as the ROM data arriving now
  always_comb begin
    w_rgb = '0;
    if (w_tagC.de) begin
      case (w_tagC.dtype)
        8'h00:   w_rgb = mem.bg_data;
        8'h32:   w_rgb = FILL_32;
        8'h34:   w_rgb = FILL_34;
        default: w_rgb = (mem.spr_data == KEY_COLOR) ? mem.bg_data : mem.spr_data;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rgb <= '0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_de  <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_hs  <= w_tagC.hs;
      r_vs  <= w_tagC.vs;
      r_de  <= w_tagC.de;
    end
  end

  assign mem.spr_sel  = r_sprSel;
  assign mem.spr_addr = r_sprAddr;
  assign mem.bg_addr  = r_bgAddr;
  assign Red    = r_rgb[23:16];
  assign Green  = r_rgb[15:8];
  assign Blue   = r_rgb[7:0];
  assign hs_out = r_hs;
  assign vs_out = r_vs;
  assign de_out = r_de;

endmodule
